// File: rtl/sdf_prim_pipe.sv
// rtl/sdf_prim_pipe.sv - four-stage pipelined signed-distance evaluator for cube/octahedron/plane primitives
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake; in_ready = !out_valid || out_ready
//   in_mode                   0=cube 1=octahedron 2=plane_y 3=reserved (result SAT_MAX)
//   in_px/py/pz, in_cx/cy/cz  sample point and primitive centre, signed fixed point
//   in_size                   cube edge, octahedron radius or plane height offset
//   in_tag                    opaque tag carried alongside the beat
//   out_valid/out_ready       output handshake; out_* held while stalled
//   out_sdf, out_inside       saturated signed distance and its sign bit
//   out_tag                   tag of the result
module sdf_prim_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TAG_W = 8,
    parameter int OCT_K = 37837
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic signed [WIDTH-1:0] in_px,
    input  logic signed [WIDTH-1:0] in_py,
    input  logic signed [WIDTH-1:0] in_pz,
    input  logic signed [WIDTH-1:0] in_cx,
    input  logic signed [WIDTH-1:0] in_cy,
    input  logic signed [WIDTH-1:0] in_cz,
    input  logic signed [WIDTH-1:0] in_size,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sdf,
    output logic                    out_inside,
    output logic [TAG_W-1:0]        out_tag
);

    // m needs two guard bits for the octahedron sum; m - size one more;
    // the octahedron product adds the width of the (positive) scale constant.
    localparam int MW = WIDTH + 2;
    localparam int DW = MW + 1;
    localparam int KW = $clog2(OCT_K + 1) + 1;
    localparam int RW = DW + KW;

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [RW-1:0]    R_MAX   = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0]    R_MIN   = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [RW-1:0]    K_EXT   = RW'(OCT_K);

    localparam logic [1:0] M_CUBE  = 2'd0;
    localparam logic [1:0] M_OCT   = 2'd1;
    localparam logic [1:0] M_PLANE = 2'd2;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [RW-1:0] v);
        if (v > R_MAX)
            return SAT_MAX;
        else if (v < R_MIN)
            return SAT_MIN;
        else
            return v[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sub_sat(input logic signed [WIDTH-1:0] p,
                                                       input logic signed [WIDTH-1:0] c);
        logic signed [WIDTH:0] d;
        d = {p[WIDTH-1], p} - {c[WIDTH-1], c};
        return sat({{(RW-WIDTH-1){d[WIDTH]}}, d});
    endfunction

    // |SAT_MIN| is not representable, so it clamps to SAT_MAX.
    function automatic logic signed [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] d);
        if (d == SAT_MIN)
            return SAT_MAX;
        else if (d[WIDTH-1])
            return -d;
        else
            return d;
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // stage 1: centre-relative offset
    logic                    s1_v;
    logic [1:0]              s1_mode;
    logic signed [WIDTH-1:0] s1_dx, s1_dy, s1_dz, s1_size;
    logic [TAG_W-1:0]        s1_tag;

    // stage 2: absolute offsets, half size; signed dy kept for the plane
    logic                    s2_v;
    logic [1:0]              s2_mode;
    logic signed [WIDTH-1:0] s2_ax, s2_ay, s2_az, s2_dy, s2_half, s2_size;
    logic [TAG_W-1:0]        s2_tag;

    // stage 3: per-mode reduction
    logic                    s3_v;
    logic [1:0]              s3_mode;
    logic signed [MW-1:0]    s3_m;
    logic signed [WIDTH-1:0] s3_half, s3_size;
    logic [TAG_W-1:0]        s3_tag;

    logic signed [WIDTH-1:0] mx_xy, mx;
    logic signed [MW-1:0]    m_next;

    always_comb begin
        mx_xy = (s2_ax > s2_ay) ? s2_ax : s2_ay;
        mx    = (mx_xy > s2_az) ? mx_xy : s2_az;
        m_next = '0;
        case (s2_mode)
            M_CUBE:  m_next = {2'b00, mx};
            M_OCT:   m_next = {2'b00, s2_ax} + {2'b00, s2_ay} + {2'b00, s2_az};
            M_PLANE: m_next = {{2{s2_dy[WIDTH-1]}}, s2_dy};
            default: m_next = '0;
        endcase
    end

    logic signed [RW-1:0]    m_ext, half_ext, size_ext, prod, r;
    logic signed [WIDTH-1:0] r_sat;

    always_comb begin
        m_ext    = {{(RW-MW){s3_m[MW-1]}}, s3_m};
        half_ext = {{(RW-WIDTH){s3_half[WIDTH-1]}}, s3_half};
        size_ext = {{(RW-WIDTH){s3_size[WIDTH-1]}}, s3_size};
        prod     = (m_ext - size_ext) * K_EXT;
        r        = R_MAX;
        case (s3_mode)
            M_CUBE:  r = m_ext - half_ext;
            M_OCT:   r = prod >>> FRAC;     // floor division by 2^FRAC
            M_PLANE: r = m_ext - size_ext;
            default: r = R_MAX;
        endcase
        r_sat = sat(r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0; s1_mode <= '0; s1_dx <= '0; s1_dy <= '0; s1_dz <= '0;
            s1_size <= '0; s1_tag <= '0;
            s2_v <= 1'b0; s2_mode <= '0; s2_ax <= '0; s2_ay <= '0; s2_az <= '0;
            s2_dy <= '0; s2_half <= '0; s2_size <= '0; s2_tag <= '0;
            s3_v <= 1'b0; s3_mode <= '0; s3_m <= '0; s3_half <= '0; s3_size <= '0;
            s3_tag <= '0;
            out_valid <= 1'b0; out_sdf <= '0; out_inside <= 1'b0; out_tag <= '0;
        end else if (adv) begin
            // bubbles travel as invalid slots; the whole pipe moves as one
            s1_v    <= in_valid;
            s1_mode <= in_mode;
            s1_dx   <= sub_sat(in_px, in_cx);
            s1_dy   <= sub_sat(in_py, in_cy);
            s1_dz   <= sub_sat(in_pz, in_cz);
            s1_size <= in_size;
            s1_tag  <= in_tag;

            s2_v    <= s1_v;
            s2_mode <= s1_mode;
            s2_ax   <= abs_sat(s1_dx);
            s2_ay   <= abs_sat(s1_dy);
            s2_az   <= abs_sat(s1_dz);
            s2_dy   <= s1_dy;
            s2_half <= s1_size >>> 1;
            s2_size <= s1_size;
            s2_tag  <= s1_tag;

            s3_v    <= s2_v;
            s3_mode <= s2_mode;
            s3_m    <= m_next;
            s3_half <= s2_half;
            s3_size <= s2_size;
            s3_tag  <= s2_tag;

            out_valid  <= s3_v;
            out_sdf    <= r_sat;
            out_inside <= r_sat[WIDTH-1];
            out_tag    <= s3_tag;
        end
    end

endmodule

// File: tb/tb_sdf_prim_pipe.sv
// tb/tb_sdf_prim_pipe.sv - self-checking bench for sdf_prim_pipe
module tb_sdf_prim_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, out_valid, out_ready, out_inside;
    logic [1:0]         in_mode;
    logic signed [31:0] in_px, in_py, in_pz, in_cx, in_cy, in_cz, in_size, out_sdf;
    logic [7:0]         in_tag, out_tag;

    sdf_prim_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_px(in_px), .in_py(in_py), .in_pz(in_pz),
        .in_cx(in_cx), .in_cy(in_cy), .in_cz(in_cz),
        .in_size(in_size), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sdf(out_sdf), .out_inside(out_inside), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    int          popped = 0;
    logic        acc;
    logic [31:0] exp_sdf[$];
    logic [7:0]  exp_tag[$];
    logic [31:0] got_sdf[256];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    endtask

    function automatic longint clamp(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference distance straight from the primitive definitions, 64-bit arithmetic.
    function automatic logic [31:0] ref_sdf(input int mode,
            input longint px, input longint py, input longint pz,
            input longint cx, input longint cy, input longint cz, input longint size);
        longint dx, dy, dz, ax, ay, az, r;
        logic [63:0] rr;
        dx = clamp(px - cx); dy = clamp(py - cy); dz = clamp(pz - cz);
        ax = clamp(labs(dx)); ay = clamp(labs(dy)); az = clamp(labs(dz));
        case (mode)
            0: begin
                r = ax;
                if (ay > r) r = ay;
                if (az > r) r = az;
                r = r - (size >>> 1);
            end
            1: r = ((ax + ay + az - size) * 37837) >>> 16;
            2: r = dy - size;
            default: r = 64'sd2147483647;
        endcase
        rr = clamp(r);
        return rr[31:0];
    endfunction

    task automatic pop_check();
        logic [31:0] es;
        logic [7:0]  et;
        if (exp_sdf.size() == 0) begin
            chk("unexpected_output", 32'(out_tag), 32'hFFFF_FFFF);
        end else begin
            es = exp_sdf.pop_front();
            et = exp_tag.pop_front();
            chk("sdf", out_sdf, es);
            chk("inside", 32'(out_inside), 32'(es[31]));
            chk("tag", 32'(out_tag), 32'(et));
            got_sdf[out_tag] = out_sdf;
            popped = popped + 1;
        end
    endtask

    // one clock: sample handshakes at negedge, return 1ns after the rising edge
    task automatic step();
        @(negedge clk);
        acc = !rst && in_valid && in_ready;
        if (!rst && out_valid && out_ready) pop_check();
        if (acc) begin
            exp_sdf.push_back(ref_sdf(int'(in_mode), longint'(in_px), longint'(in_py),
                longint'(in_pz), longint'(in_cx), longint'(in_cy), longint'(in_cz),
                longint'(in_size)));
            exp_tag.push_back(in_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic signed [31:0] px,
            input logic signed [31:0] py, input logic signed [31:0] pz,
            input logic signed [31:0] cx, input logic signed [31:0] cy,
            input logic signed [31:0] cz, input logic signed [31:0] s, input logic [7:0] t);
        in_mode = m; in_px = px; in_py = py; in_pz = pz;
        in_cx = cx; in_cy = cy; in_cz = cz; in_size = s; in_tag = t;
        in_valid = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_sdf.size() != 0; i++) step();
        chk("drain_empty", 32'(exp_sdf.size()), 32'd0);
    endtask

    // caller has driven one beat into an empty pipe with out_ready high
    task automatic lat_check(input logic [7:0] t, input logic [31:0] expv);
        step();
        chk("lat_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lat_early_valid", 32'(out_valid), 32'd0);
            step();
        end
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_sdf", out_sdf, expv);
        chk("lat_tag", 32'(out_tag), 32'(t));
        step();
    endtask

    function automatic logic signed [31:0] rnd_coord();
        int r;
        if ($urandom_range(0, 3) == 0) return $urandom;
        r = int'($urandom_range(0, 524288)) - 262144;
        return r;
    endfunction

    logic [31:0] hold_sdf;
    logic [7:0]  hold_tag;
    int          nacc, idx, base;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'd0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sdf", out_sdf, 32'd0);
        chk("rst_out_inside", 32'(out_inside), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // cube outside, 4-edge latency
        drive(2'd0, 32'h30000, 32'h8000, -32'sh10000, 0, 0, 0, 32'h20000, 8'h20);
        lat_check(8'h20, 32'h0002_0000);

        // mixed modes back to back, tags 1..3
        drive(2'd0, 32'h4000, 0, 0, 0, 0, 0, 32'h20000, 8'd1);
        step();
        drive(2'd1, 32'h10000, 32'h10000, 32'h10000, 0, 0, 0, 0, 8'd2);
        step();
        drive(2'd2, 0, 32'h18000, 0, 0, 32'h8000, 0, 32'h4000, 8'd3);
        step();
        // saturation cases
        drive(2'd0, 32'h7FFF0000, 0, 0, 32'h80000000, 0, 0, 0, 8'd4);
        step();
        drive(2'd3, 32'h1234, 32'h5678, 0, 0, 0, 0, 32'h10000, 8'd5);
        step();
        drain();
        chk("cube_inside", got_sdf[1], 32'hFFFF_4000);
        chk("oct_unit", got_sdf[2], 32'h0001_BB67);
        chk("plane_y", got_sdf[3], 32'h0000_C000);
        chk("sat_cube", got_sdf[4], 32'h7FFF_FFFF);
        chk("reserved_mode", got_sdf[5], 32'h7FFF_FFFF);

        // backpressure: 10 stalled cycles, 6 beats offered
        out_ready = 1'b0;
        nacc = 0; idx = 0; base = popped;
        hold_sdf = '0; hold_tag = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive(2'(idx % 3), idx * 32'h8000, 32'h1000 - idx * 32'h3000, 32'h20000, 0, 0, 0,
                  32'h10000, 8'(10 + idx));
            step();
            if (acc) begin nacc++; idx++; end
            if (cyc == 5) begin hold_sdf = out_sdf; hold_tag = out_tag; end
        end
        chk("bp_accepted", 32'(nacc), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_sdf", out_sdf, hold_sdf);
        chk("bp_hold_tag", 32'(out_tag), 32'(hold_tag));
        chk("bp_head_tag", 32'(out_tag), 32'd10);
        out_ready = 1'b1;
        for (int g = 0; g < 40 && idx < 6; g++) begin
            drive(2'(idx % 3), idx * 32'h8000, 32'h1000 - idx * 32'h3000, 32'h20000, 0, 0, 0,
                  32'h10000, 8'(10 + idx));
            step();
            if (acc) idx++;
        end
        drain();
        chk("bp_emerged", 32'(popped - base), 32'd6);

        // randomized traffic with random stalls
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                drive(2'($urandom_range(0, 3)), rnd_coord(), rnd_coord(), rnd_coord(),
                      rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), 8'($urandom));
            else
                in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            drive(2'd1, rnd_coord(), rnd_coord(), rnd_coord(), 0, 0, 0, 32'h8000, 8'(100 + i));
            step();
        end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        exp_sdf.delete();
        exp_tag.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2'd0, 32'h4000, 0, 0, 0, 0, 0, 32'h20000, 8'h55);
        lat_check(8'h55, 32'hFFFF_4000);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
